// File: rtl/instruction_fetch_queue_stage_pkg.sv
// Shared definitions for the instruction fetch queue stage.
// Contents: bubble/no-op encodings driven to decode, the queue entry layout
// {instruction word, word PC}, and its width.
package instruction_fetch_queue_stage_pkg;

    localparam logic [29:0] INSTR_NOP       = 30'h4;
    localparam logic [1:0]  BRANCH_JUMP_NOP = 2'b00;
    localparam logic [2:0]  IMM_SRC_NOP     = 3'b000;

    localparam int FETCH_ENTRY_W = 60;

    // Word-granular fields; bits [1:0] of both are implicit.
    typedef struct packed {
        logic [29:0] instr;
        logic [29:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/increment.sv
// Word-address incrementer used by the fetch stage.
// Ports: value_i - current address; value_o - value_i + 1, wrapping at 2^WIDTH.
module increment #(
    parameter int WIDTH = 30
) (
    input  logic [WIDTH-1:0] value_i,
    output logic [WIDTH-1:0] value_o
);

    assign value_o = value_i + WIDTH'(1);

endmodule

// File: rtl/instruction_fetch_queue_stage_fetch_queue.sv
// Synchronous DEPTH-deep FIFO of fetch entries.
// Ports: clk_i/rst_i - clock, sync active-high reset; push_i/pop_i/flush_i -
// operations (flush wins over both); wdata_i - entry to write; rdata_o -
// current head; full_o/empty_o/count_o - occupancy status.
module fetch_queue
    import instruction_fetch_queue_stage_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic                 flush_i,
    input  fetch_entry_t         wdata_i,
    output fetch_entry_t         rdata_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [CNT_WIDTH-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t         mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 do_push, do_pop;

    assign full_o  = (count_q == CNT_WIDTH'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Guarded locally so a misbehaving caller cannot corrupt the occupancy.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_WIDTH'(1);
            else if (!do_push && do_pop) count_d = count_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (!flush_i && do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/main_decoder.sv
// Main decoder slice used for fetch-side pre-decode.
// Ports: opcode_i - instruction bits [6:2];
//        branch_jump_op_o - 00 none, 01 conditional branch, 10 jal, 11 jalr;
//        imm_src_o - 000 I, 001 S, 010 B, 011 U, 100 J.
module main_decoder (
    input  logic [4:0] opcode_i,
    output logic [1:0] branch_jump_op_o,
    output logic [2:0] imm_src_o
);

    always_comb begin
        branch_jump_op_o = 2'b00;
        imm_src_o        = 3'b000;
        case (opcode_i)
            5'b11000: begin branch_jump_op_o = 2'b01; imm_src_o = 3'b010; end
            5'b11011: begin branch_jump_op_o = 2'b10; imm_src_o = 3'b100; end
            5'b11001: begin branch_jump_op_o = 2'b11; imm_src_o = 3'b000; end
            5'b01000: imm_src_o = 3'b001;
            5'b01101: imm_src_o = 3'b011;
            5'b00101: imm_src_o = 3'b011;
            default:  ;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_queue_stage.sv
// Fetch stage with a DEPTH-entry prefetch queue between I-cache and decode.
// Ports: clk_i/rst_i - clock, sync active-high reset;
//   cache_address_o/cache_data_i/cache_blocking_n_i - I-cache word interface;
//   stall_i - decode stall; branching/branch_pc - redirect request and target;
//   instr_o/pc_o/branch_jump_op_o/imm_src_o - registered decode-side outputs;
//   misaligned_o - pulse for a redirect with branch_pc[1]=1; count_o - occupancy.
module instruction_fetch_queue_stage
    import instruction_fetch_queue_stage_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic [31:2]          cache_address_o,
    input  logic [31:2]          cache_data_i,
    input  logic                 cache_blocking_n_i,
    input  logic                 stall_i,
    input  logic                 branching,
    input  logic [31:1]          branch_pc,
    output logic [31:2]          instr_o,
    output logic [31:2]          pc_o,
    output logic [1:0]           branch_jump_op_o,
    output logic [2:0]           imm_src_o,
    output logic                 misaligned_o,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [29:0]  fetch_pc_q, fetch_pc_d, fetch_pc_inc;
    logic [29:0]  instr_q, instr_d;
    logic [29:0]  pc_q, pc_d;
    logic [1:0]   bj_op_q, bj_op_d;
    logic [2:0]   imm_src_q, imm_src_d;
    logic         misaligned_q, misaligned_d;

    logic         branching_eff, push, pop, full, empty;
    fetch_entry_t wr_entry, head;
    logic [1:0]   head_bj_op;
    logic [2:0]   head_imm_src;

    // Redirects are only honoured while decode is not stalled.
    assign branching_eff = branching && !stall_i;
    assign pop           = !stall_i && !branching && !empty;
    assign push          = cache_blocking_n_i && !branching_eff && (!full || pop);

    assign wr_entry.instr = cache_data_i;
    assign wr_entry.pc    = fetch_pc_q;

    fetch_queue #(
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (branching_eff),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count_o)
    );

    increment #(.WIDTH(30)) u_increment (
        .value_i (fetch_pc_q),
        .value_o (fetch_pc_inc)
    );

    main_decoder u_main_decoder (
        .opcode_i         (head.instr[4:0]),
        .branch_jump_op_o (head_bj_op),
        .imm_src_o        (head_imm_src)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (branching_eff)  fetch_pc_d = branch_pc[31:2];
        else if (push)      fetch_pc_d = fetch_pc_inc;
    end

    always_comb begin
        instr_d      = instr_q;
        pc_d         = pc_q;
        bj_op_d      = bj_op_q;
        imm_src_d    = imm_src_q;
        // Pulse only: cleared on any cycle that is not an accepted redirect.
        misaligned_d = branching_eff && branch_pc[1];
        if (!stall_i) begin
            if (pop) begin
                instr_d   = head.instr;
                pc_d      = head.pc;
                bj_op_d   = head_bj_op;
                imm_src_d = head_imm_src;
            end else begin
                // Redirect or empty queue: bubble, PC holds.
                instr_d   = INSTR_NOP;
                bj_op_d   = BRANCH_JUMP_NOP;
                imm_src_d = IMM_SRC_NOP;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q   <= RESET_PC[31:2];
            instr_q      <= INSTR_NOP;
            pc_q         <= '0;
            bj_op_q      <= BRANCH_JUMP_NOP;
            imm_src_q    <= IMM_SRC_NOP;
            misaligned_q <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            bj_op_q      <= bj_op_d;
            imm_src_q    <= imm_src_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign cache_address_o  = fetch_pc_q;
    assign instr_o          = instr_q;
    assign pc_o             = pc_q;
    assign branch_jump_op_o = bj_op_q;
    assign imm_src_o        = imm_src_q;
    assign misaligned_o     = misaligned_q;

endmodule

// File: doc/instruction_fetch_queue_stage.md
Name: instruction_fetch_queue_stage

Overview:
Parametrised successor to the single-register fetch stage. It decouples instruction-cache fetch from decode through a DEPTH-entry prefetch queue, so fetch keeps running while decode is stalled. Branch redirect flushes the queue. A misaligned branch target raises a flag. The block sits between the instruction cache and the decode stage, and partially pre-decodes the queue head with the existing main decoder.

Parameters:
DEPTH, 4, queue entries; power of two, at least 2
RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] ignored
CNT_WIDTH, $clog2(DEPTH+1), occupancy counter width; derived, do not override

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
cache_address_o  out  30 [31:2]  word address to I-cache; combinational copy of fetch_pc
cache_data_i  in  30 [31:2]  instruction word (bits [1:0] implicitly 2'b11)
cache_blocking_n_i  in  1  high = cache_data_i valid for cache_address_o this cycle
stall_i  in  1  decode stall; hold outputs, no pop
branching  in  1  redirect request; sampled only when stall_i=0
branch_pc  in  31 [31:1]  redirect target
instr_o  out  30 [31:2]  instruction to decode
pc_o  out  30 [31:2]  word PC of instr_o
branch_jump_op_o  out  2  pre-decoded branch/jump op
imm_src_o  out  3  pre-decoded immediate source
misaligned_o  out  1  one-cycle pulse: accepted redirect had branch_pc[1]=1
count_o  out  CNT_WIDTH  current queue occupancy

Behaviour:
- Reset (sync, rst_i=1 at posedge), overriding all other inputs:
  - fetch_pc = RESET_PC[31:2]; queue empty; count_o = 0
  - instr_o = INSTR_NOP (30'h4); branch_jump_op_o = 2'b00; imm_src_o = 3'b000; pc_o = 0; misaligned_o = 0
- Queue entry = {instr[31:2], pc[31:2]}. Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked separately to distinguish full from empty.
- pop = !stall_i && !branching && !empty.
- push = cache_blocking_n_i && !branching_eff && (!full || pop), where branching_eff = branching && !stall_i.
  - A full queue therefore accepts a push in the same cycle as a pop; count is unchanged.
- On push: the entry is written with {cache_data_i, fetch_pc}, and fetch_pc <= fetch_pc + 1 through the increment sub-block. fetch_pc wraps modulo 2^30 (30'h3FFF_FFFF -> 0).
- Cache miss (cache_blocking_n_i=0): no push; fetch_pc holds.
- Output register, updated only when stall_i=0:
  - branching=1: instr_o = INSTR_NOP, branch_jump_op_o = 00, imm_src_o = 000, pc_o holds.
  - pop: the head entry loads instr_o and pc_o. branch_jump_op_o and imm_src_o come from main_decoder on head instr[6:2]. Output latency: an instruction accepted at edge N is visible at edge N+1 at the earliest, when the queue was empty.
  - empty, no branch: bubble (INSTR_NOP, 00, 000); pc_o holds.
- stall_i=1: all outputs hold. The queue still fills until full; branching is ignored (the issuer holds it until stall_i=0).
- Accepted redirect (branching && !stall_i):
  - Queue flushed: pointers and count go to 0.
  - fetch_pc <= branch_pc[31:2].
  - A same-cycle cache response is discarded.
  - misaligned_o <= branch_pc[1], otherwise 0 the next cycle. The target is still truncated to the word address; the trap is taken downstream.
- count_o is registered and reflects the state after the last edge.

Decomposition:
- Shared package:
  - INSTR_NOP = 30'h4
  - BRANCH_JUMP_NOP = 2'b00
  - IMM_SRC_NOP = 3'b000
  - fetch entry struct/width constant FETCH_ENTRY_W = 60
- Sub-module fetch_queue: synchronous DEPTH-deep FIFO with push, pop, flush, full, empty and count, where flush has priority over push and pop.
- main_decoder and increment are reused unchanged.

Test Plan:
- Reset then stream: cache always ready, words 0x100+k. Expect instr_o sequence 0x100, 0x101, … with pc_o = 0, 1, 2, … The first valid output is 2 cycles after reset release, with 1 bubble between.
- Stall fill: stall_i=1 for 10 cycles with cache ready. count_o rises to 4 and holds, cache_address_o freezes at 4 past the stall start, and outputs hold. On release, 4 queued words drain in order with no duplicates or gaps.
- Full with simultaneous push/pop: queue at 4, stall_i=0, cache ready. count_o stays at 4 and pc_o increments by 1 per cycle.
- Branch flush: queue full, branching=1 with branch_pc=31'h0000_0040 (byte address 0x80). Next cycle: count_o = 0, instr_o = 0x4, cache_address_o = 30'h20, misaligned_o = 0. The next instruction out has pc_o = 30'h20.
- Misaligned redirect: branch_pc=31'h0000_0041. misaligned_o is 1 for exactly one cycle and fetch resumes at 30'h20. A branch asserted during stall_i=1 has no effect until the stall drops.
- Wrap and mid-operation reset: fetch_pc = 30'h3FFF_FFFF followed by a push gives cache_address_o = 0. Then rst_i=1 with the queue half full: next cycle count_o = 0, instr_o = 0x4, and cache_address_o = RESET_PC[31:2].
